// File: rtl/mos6502s_alu_seq.sv
// Sequential 6502-style ALU: latches an operation, computes in EXEC, optionally
// applies decimal correction in ADJ, then pulses done and a register-file strobe in WB.
module mos6502s_alu_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] op,
  input  logic [1:0] dest,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  input  logic       c_in,
  input  logic       d_flag,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       load_a,
  output logic       load_x,
  output logic       load_y,
  output logic       flag_n,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_v
);

  localparam logic [3:0] OpAdc = 4'd0;
  localparam logic [3:0] OpSbc = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOra = 4'd3;
  localparam logic [3:0] OpEor = 4'd4;
  localparam logic [3:0] OpAsl = 4'd5;
  localparam logic [3:0] OpLsr = 4'd6;
  localparam logic [3:0] OpRol = 4'd7;
  localparam logic [3:0] OpRor = 4'd8;
  localparam logic [3:0] OpInc = 4'd9;
  localparam logic [3:0] OpDec = 4'd10;
  localparam logic [3:0] OpCmp = 4'd11;

  typedef enum logic [1:0] {StIdle, StExec, StAdj, StWb} state_e;

  state_e     r_state, w_state_next;
  logic [3:0] r_op;
  logic [1:0] r_dest;
  logic [7:0] r_a, r_b;
  logic       r_c, r_d, r_hc;
  logic [7:0] r_result;
  logic       r_n, r_z, r_c_flag, r_v;

  logic [7:0] w_b_eff, w_res, w_adj_res;
  logic       w_cin, w_hc, w_c, w_v, w_wr_res, w_adj_c, w_hi_fix;
  logic [8:0] w_sum, w_lo_adj;
  logic [4:0] w_low;
  logic       w_arith_sub, w_dec_op, w_ld_en;

  assign w_arith_sub = (r_op == OpSbc) || (r_op == OpCmp);
  assign w_b_eff     = w_arith_sub ? ~r_b : r_b;
  assign w_cin       = (r_op == OpCmp) ? 1'b1 : r_c;
  assign w_sum       = {1'b0, r_a} + {1'b0, w_b_eff} + {8'd0, w_cin};
  assign w_low       = {1'b0, r_a[3:0]} + {1'b0, w_b_eff[3:0]} + {4'd0, w_cin};
  assign w_hc        = w_low[4];
  assign w_dec_op    = r_d && ((r_op == OpAdc) || (r_op == OpSbc));

  always_comb begin
    w_res    = r_a;
    w_c      = r_c_flag;
    w_v      = r_v;
    w_wr_res = 1'b1;
    case (r_op)
      OpAdc, OpSbc, OpCmp: begin
        w_res    = w_sum[7:0];
        w_c      = w_sum[8];
        w_v      = (r_a[7] == w_b_eff[7]) && (w_sum[7] != r_a[7]);
        w_wr_res = (r_op != OpCmp);
      end
      OpAnd: w_res = r_a & r_b;
      OpOra: w_res = r_a | r_b;
      OpEor: w_res = r_a ^ r_b;
      OpAsl: begin w_res = {r_a[6:0], 1'b0}; w_c = r_a[7]; end
      OpLsr: begin w_res = {1'b0, r_a[7:1]}; w_c = r_a[0]; end
      OpRol: begin w_res = {r_a[6:0], r_c};  w_c = r_a[7]; end
      OpRor: begin w_res = {r_c, r_a[7:1]};  w_c = r_a[0]; end
      OpInc: w_res = r_a + 8'd1;
      OpDec: w_res = r_a - 8'd1;
      default: w_res = r_a;
    endcase
  end

  // Decimal correction works on the binary result and carry captured in EXEC.
  always_comb begin
    w_lo_adj  = {1'b0, r_result};
    w_hi_fix  = 1'b0;
    w_adj_res = r_result;
    w_adj_c   = r_c_flag;
    if (r_op == OpAdc) begin
      if ((r_result[3:0] > 4'd9) || r_hc) w_lo_adj = {1'b0, r_result} + 9'h006;
      w_hi_fix  = (w_lo_adj[7:4] > 4'd9) || r_c_flag || w_lo_adj[8];
      w_adj_res = w_lo_adj[7:0] + (w_hi_fix ? 8'h60 : 8'h00);
      w_adj_c   = w_hi_fix;
    end else begin
      w_adj_res = r_result - (r_hc ? 8'h00 : 8'h06) - (r_c_flag ? 8'h00 : 8'h60);
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (start) w_state_next = StExec;
      StExec: w_state_next = w_dec_op ? StAdj : StWb;
      StAdj:  w_state_next = StWb;
      StWb:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_op     <= 4'd0;
      r_dest   <= 2'd0;
      r_a      <= 8'd0;
      r_b      <= 8'd0;
      r_c      <= 1'b0;
      r_d      <= 1'b0;
      r_hc     <= 1'b0;
      r_result <= 8'd0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
      r_c_flag <= 1'b0;
      r_v      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StIdle && start) begin
        r_op   <= op;
        r_dest <= dest;
        r_a    <= a_in;
        r_b    <= b_in;
        r_c    <= c_in;
        r_d    <= d_flag;
      end
      if (r_state == StExec) begin
        if (w_wr_res) r_result <= w_res;
        r_n      <= w_res[7];
        r_z      <= (w_res == 8'd0);
        r_c_flag <= w_c;
        r_v      <= w_v;
        r_hc     <= w_hc;
      end
      if (r_state == StAdj) begin
        r_result <= w_adj_res;
        r_c_flag <= w_adj_c;
      end
    end
  end

  assign w_ld_en = (r_state == StWb) && (r_op != OpCmp);
  assign busy    = (r_state != StIdle);
  assign done    = (r_state == StWb);
  assign load_a  = w_ld_en && (r_dest == 2'd0);
  assign load_x  = w_ld_en && (r_dest == 2'd1);
  assign load_y  = w_ld_en && (r_dest == 2'd2);
  assign result  = r_result;
  assign flag_n  = r_n;
  assign flag_z  = r_z;
  assign flag_c  = r_c_flag;
  assign flag_v  = r_v;

endmodule

// File: tb/tb_mos6502s_alu_seq.sv
// Directed self-checking bench for mos6502s_alu_seq with hand-computed expectations.
module tb_mos6502s_alu_seq;

  logic       clk, rst, start, c_in, d_flag;
  logic [3:0] op;
  logic [1:0] dest;
  logic [7:0] a_in, b_in, result;
  logic       busy, done, load_a, load_x, load_y, flag_n, flag_z, flag_c, flag_v;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int strobe_cnt = 0;

  mos6502s_alu_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dest(dest), .a_in(a_in), .b_in(b_in),
    .c_in(c_in), .d_flag(d_flag), .busy(busy), .done(done), .result(result),
    .load_a(load_a), .load_x(load_x), .load_y(load_y),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    strobe_cnt += int'(load_a) + int'(load_x) + int'(load_y);
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns the number of falling edges after the accept edge until done is seen.
  task automatic run_op(input logic [3:0] o, input logic [1:0] dst, input logic [7:0] a,
                        input logic [7:0] b, input logic c, input logic d,
                        output int lat, output logic [2:0] strb);
    bit seen = 0;
    @(negedge clk);
    op = o; dest = dst; a_in = a; b_in = b; c_in = c; d_flag = d; start = 1'b1;
    @(posedge clk);
    lat  = 0;
    strb = 3'b000;
    while (!seen && lat < 10) begin
      @(negedge clk);
      start = 1'b0;
      a_in = ~a_in; b_in = ~b_in; c_in = ~c_in; op = 4'd12;
      lat++;
      if (done) begin
        seen = 1;
        strb = {load_y, load_x, load_a};
      end
    end
    if (!seen) check_eq("done_timeout", 16'd0, 16'd1);
  endtask

  int         lat;
  logic [2:0] strb;
  int         d0, s0;

  initial begin
    rst = 1'b1; start = 1'b0; op = 4'd0; dest = 2'd0; a_in = 8'd0; b_in = 8'd0;
    c_in = 1'b0; d_flag = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_result", {8'd0, result}, 16'h0000);
    check_eq("rst_flags", {12'd0, flag_n, flag_z, flag_c, flag_v}, 16'h0);
    check_eq("rst_ctl", {11'd0, busy, done, load_a, load_x, load_y}, 16'h0);
    rst = 1'b0;

    run_op(4'd0, 2'd0, 8'h50, 8'h50, 1'b0, 1'b0, lat, strb);
    check_eq("adc_lat", 16'(lat), 16'd2);
    check_eq("adc_res", {8'd0, result}, 16'h00A0);
    check_eq("adc_nzcv", {12'd0, flag_n, flag_z, flag_c, flag_v}, 16'b1001);
    check_eq("adc_strb", {13'd0, strb}, 16'b001);

    run_op(4'd0, 2'd1, 8'h19, 8'h28, 1'b0, 1'b1, lat, strb);
    check_eq("dadc_lat", 16'(lat), 16'd3);
    check_eq("dadc_res", {8'd0, result}, 16'h0047);
    check_eq("dadc_c", {15'd0, flag_c}, 16'd0);
    check_eq("dadc_strb", {13'd0, strb}, 16'b010);

    run_op(4'd0, 2'd1, 8'h99, 8'h01, 1'b0, 1'b1, lat, strb);
    check_eq("dadc99_res", {8'd0, result}, 16'h0000);
    // N/Z reflect the binary sum 0x9A, not the decimal result
    check_eq("dadc99_nzcv", {12'd0, flag_n, flag_z, flag_c, flag_v}, 16'b1010);

    run_op(4'd1, 2'd0, 8'h10, 8'h01, 1'b1, 1'b1, lat, strb);
    check_eq("dsbc_lat", 16'(lat), 16'd3);
    check_eq("dsbc_res", {8'd0, result}, 16'h0009);
    check_eq("dsbc_c", {15'd0, flag_c}, 16'd1);

    run_op(4'd11, 2'd0, 8'h10, 8'h20, 1'b0, 1'b1, lat, strb);
    check_eq("cmp_lat", 16'(lat), 16'd2);
    check_eq("cmp_nzcv", {12'd0, flag_n, flag_z, flag_c, flag_v}, 16'b1000);
    check_eq("cmp_strb", {13'd0, strb}, 16'b000);

    run_op(4'd8, 2'd2, 8'h01, 8'h00, 1'b1, 1'b0, lat, strb);
    check_eq("ror_res", {8'd0, result}, 16'h0080);
    check_eq("ror_nzc", {13'd0, flag_n, flag_z, flag_c}, 16'b101);
    check_eq("ror_strb", {13'd0, strb}, 16'b100);

    run_op(4'd9, 2'd0, 8'hFF, 8'h00, 1'b0, 1'b0, lat, strb);
    check_eq("inc_res", {8'd0, result}, 16'h0000);
    check_eq("inc_nzc", {13'd0, flag_n, flag_z, flag_c}, 16'b011);

    run_op(4'd2, 2'd3, 8'hF0, 8'h3C, 1'b0, 1'b0, lat, strb);
    check_eq("and_res", {8'd0, result}, 16'h0030);
    check_eq("and_strb", {13'd0, strb}, 16'b000);
    check_eq("and_c_hold", {15'd0, flag_c}, 16'd1);

    run_op(4'd10, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, lat, strb);
    check_eq("dec_res", {8'd0, result}, 16'h00FF);
    check_eq("dec_nz", {14'd0, flag_n, flag_z}, 16'b10);

    run_op(4'd6, 2'd1, 8'h81, 8'h00, 1'b1, 1'b0, lat, strb);
    check_eq("lsr_res", {8'd0, result}, 16'h0040);
    check_eq("lsr_nzc", {13'd0, flag_n, flag_z, flag_c}, 16'b001);

    run_op(4'd1, 2'd0, 8'h80, 8'h01, 1'b1, 1'b0, lat, strb);
    check_eq("sbc_res", {8'd0, result}, 16'h007F);
    check_eq("sbc_nzcv", {12'd0, flag_n, flag_z, flag_c, flag_v}, 16'b0011);

    run_op(4'd13, 2'd0, 8'h5A, 8'h00, 1'b0, 1'b0, lat, strb);
    check_eq("pass13_res", {8'd0, result}, 16'h005A);

    repeat (2) @(negedge clk);
    check_eq("hold_res", {8'd0, result}, 16'h005A);

    // start raised again during EXEC must not start a second operation
    d0 = done_cnt;
    @(negedge clk);
    op = 4'd3; dest = 2'd0; a_in = 8'h0F; b_in = 8'hA0; c_in = 1'b0; d_flag = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("ign_done_cnt", 16'(done_cnt - d0), 16'd1);
    check_eq("ign_res", {8'd0, result}, 16'h00AF);
    check_eq("ign_busy", {15'd0, busy}, 16'd0);

    // reset during ADJ aborts at once
    d0 = done_cnt;
    s0 = strobe_cnt;
    @(negedge clk);
    op = 4'd0; dest = 2'd0; a_in = 8'h19; b_in = 8'h28; c_in = 1'b0; d_flag = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_eq("adj_busy", {15'd0, busy}, 16'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("mid_rst_result", {8'd0, result}, 16'h0000);
    check_eq("mid_rst_flags", {12'd0, flag_n, flag_z, flag_c, flag_v}, 16'h0);
    check_eq("mid_rst_ctl", {11'd0, busy, done, load_a, load_x, load_y}, 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("abort_done", 16'(done_cnt - d0), 16'd0);
    check_eq("abort_strb", 16'(strobe_cnt - s0), 16'd0);

    run_op(4'd0, 2'd1, 8'h19, 8'h28, 1'b0, 1'b1, lat, strb);
    check_eq("post_rst_lat", 16'(lat), 16'd3);
    check_eq("post_rst_res", {8'd0, result}, 16'h0047);
    check_eq("post_rst_strb", {13'd0, strb}, 16'b010);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
